// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizes for the 3x3 convolution sequencer
package conv_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;
  localparam int KSIZE = 3;
  localparam int TAPS = 9;
  localparam int PIX_W = 8;
  localparam int ACC_W = 16;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window/pixel counters and image read address for the 3x3 walk
module conv_addr_gen import conv_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fetch,
  input  logic          adv,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    tap,
  output logic          last_tap,
  output logic          last_pix,
  output logic [7:0]    row,
  output logic [7:0]    col
);
  logic [7:0] row_q, row_d, col_q, col_d;
  logic [1:0] kr_q, kr_d, kc_q, kc_d;
  logic [AW-1:0] addr_q, addr_d, cur;
  logic col_last, kc_last, kr_last;
  assign col_last = col_q == 8'(IMG_W - KSIZE);
  assign kc_last = kc_q == 2'(KSIZE - 1);
  assign kr_last = kr_q == 2'(KSIZE - 1);
  assign cur = AW'(BASE_ADDR) + (AW'(row_q) + AW'(kr_q)) * AW'(IMG_W) + AW'(col_q) + AW'(kc_q);
  // the address is live during a read and frozen at its last value otherwise
  assign mem_addr = fetch ? cur : addr_q;
  assign tap = 4'(kr_q) * 4'(KSIZE) + 4'(kc_q);
  assign last_tap = kr_last && kc_last;
  assign last_pix = col_last && row_q == 8'(IMG_H - KSIZE);
  assign row = row_q;
  assign col = col_q;
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    kr_d = kr_q;
    kc_d = kc_q;
    addr_d = fetch ? cur : addr_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      kr_d = '0;
      kc_d = '0;
    end else begin
      if (fetch) begin
        kc_d = kc_last ? 2'd0 : kc_q + 2'd1;
        kr_d = !kc_last ? kr_q : kr_last ? 2'd0 : kr_q + 2'd1;
      end
      if (adv) begin
        col_d = col_last ? 8'd0 : col_q + 8'd1;
        row_d = col_last ? row_q + 8'd1 : row_q;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
      addr_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: FSM, filter bank and serial multiply-accumulate for a 3x3 valid-only convolution
module conv3x3_sequencer import conv_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             coef_we,
  input  logic [3:0]       coef_addr,
  input  logic [PIX_W-1:0] coef_data,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic [7:0]       res_row,
  output logic [7:0]       res_col
);
  state_t state_q, state_d;
  logic [PIX_W-1:0] coef_q [TAPS];
  logic [PIX_W-1:0] coef_d [TAPS];
  logic [ACC_W-1:0] acc_q, acc_d, prod;
  logic [ACC_W:0] sum;
  logic ovf_q, ovf_d, rd_q, rd_d;
  logic [3:0] tap, tap_q, tap_d;
  logic last_tap, last_pix, start_ok, hs, fetch;
  assign fetch = state_q == FETCH;
  assign start_ok = state_q == IDLE && start;
  assign hs = state_q == OUT && res_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign mem_rd = fetch;
  assign res_valid = state_q == OUT;
  assign res_data = acc_q;
  assign res_ovf = ovf_q;
  conv_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .BASE_ADDR(BASE_ADDR)) u_addr (
    .clk(clk), .rst(rst), .clr(start_ok), .fetch(fetch), .adv(hs && !last_pix),
    .mem_addr(mem_addr), .tap(tap), .last_tap(last_tap), .last_pix(last_pix),
    .row(res_row), .col(res_col)
  );
  always_comb begin
    state_d = state_q;
    coef_d = coef_q;
    rd_d = fetch;
    tap_d = tap;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = last_tap ? DRAIN : FETCH;
      DRAIN:   state_d = OUT;
      OUT:     state_d = !res_ready ? OUT : last_pix ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE && coef_we && coef_addr < 4'(TAPS)) coef_d[coef_addr] = coef_data;
    // pixel arrives one cycle after its read, so pair it with the delayed tap index
    prod = ACC_W'(coef_q[tap_q]) * ACC_W'(mem_rdata);
    sum = {1'b0, acc_q} + {1'b0, prod};
    acc_d = rd_q ? sum[ACC_W-1:0] : acc_q;
    ovf_d = rd_q ? ovf_q | sum[ACC_W] : ovf_q;
    if (start_ok || (hs && !last_pix)) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coef_q <= '{default: '0};
      acc_q <= '0;
      ovf_q <= 1'b0;
      rd_q <= 1'b0;
      tap_q <= '0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      rd_q <= rd_d;
      tap_q <= tap_d;
    end
  end
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// tb_conv3x3_sequencer: directed checks of the 3x3 sequencer on a 4x4 image
module tb_conv3x3_sequencer;
  logic clk = 0, rst = 1, start = 0, coef_we = 0, res_ready = 1;
  logic [3:0] coef_addr = 0;
  logic [7:0] coef_data = 0, mem_rdata = 0;
  logic busy, done, mem_rd, res_valid, res_ovf;
  logic [15:0] mem_addr, res_data;
  logic [7:0] res_row, res_col;
  logic [7:0] mem [16];
  int total = 0, bad = 0;
  int got_n, got_done;
  logic [15:0] got_d [4];
  logic got_o [4];
  logic [7:0] got_r [4], got_c [4];
  int er [4] = '{0, 0, 1, 1};
  int ec [4] = '{0, 1, 0, 1};

  conv3x3_sequencer #(.IMG_W(4), .IMG_H(4), .AW(16), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];

  task set_coef(input int a, input logic [7:0] v);
    @(negedge clk);
    coef_we = 1;
    coef_addr = 4'(a);
    coef_data = v;
    @(negedge clk);
    coef_we = 0;
  endtask

  task fill_coef(input logic [7:0] v);
    for (int k = 0; k < 9; k++) set_coef(k, v);
  endtask

  task fill_mem(input bit by_addr, input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = by_addr ? 8'(i) : v;
  endtask

  task pulse_start;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task collect(input int budget);
    got_n = 0;
    got_done = 0;
    for (int i = 0; i < 4; i++) begin
      got_d[i] = 'x;
      got_o[i] = 'x;
      got_r[i] = 'x;
      got_c[i] = 'x;
    end
    for (int i = 0; i < budget; i++) begin
      if (res_valid && res_ready) begin
        if (got_n < 4) begin
          got_d[got_n] = res_data;
          got_o[got_n] = res_ovf;
          got_r[got_n] = res_row;
          got_c[got_n] = res_col;
        end
        got_n++;
      end
      if (done) got_done++;
      @(negedge clk);
    end
  endtask

  task check_pass(input string tag, input int d0, input int d1, input int d2, input int d3, input logic eo);
    int ed [4];
    ed = '{d0, d1, d2, d3};
    total++;
    if (got_n !== 4 || got_done !== 1) begin
      bad++;
      $display("FAIL %s_count results=%0d dones=%0d exp 4 and 1", tag, got_n, got_done);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_d[i] !== 16'(ed[i]) || got_o[i] !== eo || got_r[i] !== 8'(er[i]) || got_c[i] !== 8'(ec[i])) begin
        bad++;
        $display("FAIL %s_res%0d got d=%0d ovf=%b rc=%0d,%0d exp d=%0d ovf=%b rc=%0d,%0d",
                 tag, i, got_d[i], got_o[i], got_r[i], got_c[i], ed[i], eo, er[i], ec[i]);
      end
    end
  endtask

  task test_reset;
    @(negedge clk);
    total++;
    if ({busy, done, mem_rd, mem_addr, res_valid, res_data, res_ovf, res_row, res_col} !== 53'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b addr=%h valid=%b data=%h ovf=%b rc=%0d,%0d exp all 0",
               busy, done, mem_rd, mem_addr, res_valid, res_data, res_ovf, res_row, res_col);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task test_ones;
    int n;
    fill_mem(0, 8'd1);
    fill_coef(8'd1);
    pulse_start;
    total++;
    if (busy !== 1 || mem_rd !== 1 || mem_addr !== 16'd0) begin
      bad++;
      $display("FAIL start_timing got busy=%b rd=%b addr=%0d exp 1 1 0", busy, mem_rd, mem_addr);
    end
    n = 1;
    while (!res_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 11) begin
      bad++;
      $display("FAIL valid_latency got %0d cycles exp 11", n);
    end
    collect(60);
    check_pass("ones", 9, 9, 9, 9, 1'b0);
    total++;
    if (busy !== 0) begin
      bad++;
      $display("FAIL ones_idle got busy=%b exp 0", busy);
    end
  endtask

  task test_center;
    fill_coef(8'd0);
    set_coef(4, 8'd1);
    fill_mem(1, 8'd0);
    pulse_start;
    collect(60);
    check_pass("center", 5, 6, 9, 10, 1'b0);
  endtask

  task test_sat;
    fill_coef(8'd255);
    fill_mem(0, 8'd255);
    pulse_start;
    collect(60);
    check_pass("sat", 60937, 60937, 60937, 60937, 1'b1);
  endtask

  task test_backpressure;
    int n;
    fill_coef(8'd1);
    fill_mem(0, 8'd1);
    res_ready = 0;
    pulse_start;
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!res_valid) begin
      bad++;
      $display("FAIL stall_timeout got valid=%b exp 1", res_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1 || mem_rd !== 0 || {res_data, res_ovf, res_row, res_col} !== {16'd9, 1'b0, 8'd0, 8'd0}) begin
        bad++;
        $display("FAIL stall_hold%0d got valid=%b rd=%b d=%0d ovf=%b rc=%0d,%0d exp 1 0 9 0 0,0",
                 i, res_valid, mem_rd, res_data, res_ovf, res_row, res_col);
      end
    end
    res_ready = 1;
    collect(60);
    check_pass("stall", 9, 9, 9, 9, 1'b0);
  endtask

  task test_ignore;
    fill_coef(8'd0);
    set_coef(4, 8'd1);
    fill_mem(1, 8'd0);
    pulse_start;
    repeat (3) @(negedge clk);
    coef_we = 1;
    coef_addr = 4'd0;
    coef_data = 8'd7;
    start = 1;
    @(negedge clk);
    coef_we = 0;
    start = 0;
    collect(60);
    check_pass("busy_write", 5, 6, 9, 10, 1'b0);
    pulse_start;
    collect(60);
    check_pass("bank_frozen", 5, 6, 9, 10, 1'b0);
  endtask

  task test_done_start;
    int n;
    pulse_start;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout got done=%b exp 1", done);
    end
    start = 1;
    @(negedge clk);
    start = 0;
    total++;
    if (busy !== 0 || mem_rd !== 0 || done !== 0) begin
      bad++;
      $display("FAIL done_start got busy=%b rd=%b done=%b exp 0 0 0", busy, mem_rd, done);
    end
  endtask

  task test_reset_mid;
    int n;
    fill_coef(8'd1);
    fill_mem(0, 8'd1);
    pulse_start;
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (mem_rd !== 1 || res_col !== 8'd1) begin
      bad++;
      $display("FAIL mid_fetch got rd=%b col=%0d exp 1 1", mem_rd, res_col);
    end
    rst = 1;
    #1;
    total++;
    if ({busy, done, mem_rd, mem_addr, res_valid, res_data, res_ovf, res_row, res_col} !== 53'd0) begin
      bad++;
      $display("FAIL mid_reset got busy=%b done=%b rd=%b addr=%h valid=%b data=%h ovf=%b rc=%0d,%0d exp all 0",
               busy, done, mem_rd, mem_addr, res_valid, res_data, res_ovf, res_row, res_col);
    end
    @(negedge clk);
    rst = 0;
    pulse_start;
    collect(60);
    check_pass("cleared_bank", 0, 0, 0, 0, 1'b0);
    fill_coef(8'd1);
    pulse_start;
    collect(60);
    check_pass("after_reset", 9, 9, 9, 9, 1'b0);
  endtask

  initial begin
    test_reset;
    test_ones;
    test_center;
    test_sat;
    test_backpressure;
    test_ignore;
    test_done_start;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv3x3_sequencer.md
# conv3x3_sequencer

Sequencer for the 3x3 convolution datapath: holds a 9-tap 8-bit filter bank and walks a 3x3 window over an IMG_H x IMG_W image in external memory. For each output pixel it fetches the 9 window pixels and multiply-accumulates them serially against the filter in one 8x8 multiplier and a 16-bit accumulator. Each result is presented on a valid/ready output port. The block sits between the image buffer and the downstream feature-map writer.

## Interface
- IMG_W, 8: image width in pixels (≥3)
- IMG_H, 8: image height in pixels (≥3)
- AW, 16: memory address width
- BASE_ADDR, 0: address of image pixel (0,0); row-major layout
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a full image pass when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result handshake
- coef_we  in  1  filter write strobe
- coef_addr  in  4  tap index 0..8 = kr*3+kc; values 9..15 ignored
- coef_data  in  8  unsigned tap value
- mem_rd  out  1  image read strobe
- mem_addr  out  AW  read address
- mem_rdata  in  8  unsigned pixel, valid exactly 1 cycle after mem_rd
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  16  convolution sum mod 2^16
- res_ovf  out  1  sum exceeded 16 bits for this pixel
- res_row, res_col  out  8 each  output pixel coordinates

## Operation
- Decided: one clock; reset is asynchronous and active-high.
- Output grid is valid-only, with no padding: rows 0..IMG_H-3 and cols 0..IMG_W-3, raster order with col fastest.
- Window tap k = kr*3+kc reads address BASE_ADDR + (row+kr)*IMG_W + (col+kc).
- Products are 8x8 unsigned, giving 16 bits. The accumulator is 16 bits and wraps. A carry out of bit 15 on any add sets the per-pixel sticky ovf.
- FSM states:
  - IDLE: busy=0. start moves to FETCH at row=col=0.
  - FETCH: 9 cycles, with mem_rd=1 and taps k=0..8 in order. Each returned pixel is accumulated the cycle after its read. The accumulator and ovf clear on entry.
  - DRAIN: 1 cycle; accumulates tap 8.
  - OUT: res_valid=1. On res_valid&&res_ready:
    - if it was the last pixel, go to DONE;
    - otherwise advance col, wrapping to 0 and incrementing row, and go to FETCH.
  - DONE: 1 cycle, done=1, then IDLE.
- coef_we is honoured only in IDLE. Writes while busy are dropped and the filter bank stays frozen for the whole pass.
- start while busy (including the DONE cycle) is ignored.
- start and coef_we in the same IDLE cycle: the write is applied and the pass uses the new tap.

## Timing
- Reset values:
  - all outputs 0;
  - filter bank all 0;
  - FSM in IDLE;
  - row/col counters 0.
- Reset mid-pass aborts immediately. No res_valid or done is produced for the aborted pass.
- start in cycle T gives busy=1 and the first mem_rd at T+1.
- Per pixel there are 9 FETCH cycles and 1 DRAIN cycle, and res_valid rises at FETCH entry + 10.
- With res_ready held high, throughput is 11 cycles/pixel. A full 8x8 pass is 36 pixels, 396 cycles plus done.
- res_data, res_ovf, res_row and res_col stay stable while res_valid=1 and res_ready=0.
- mem_rd=0 outside FETCH, including during backpressure.
- mem_addr holds its last value when mem_rd=0.

## Structure
- Package conv_pkg:
  - state enum {IDLE, FETCH, DRAIN, OUT, DONE};
  - KSIZE=3, TAPS=9;
  - PIX_W=8, ACC_W=16.
- Sub-module conv_addr_gen: holds the row/col/kr/kc counters and generates mem_addr. It reports tap index, last-tap and last-pixel flags.
- The top level holds the FSM, filter bank, multiplier and accumulator.

## Test plan
- IMG_W=IMG_H=4, all taps=1, all pixels=1 -> 4 results of 9, coordinates (0,0),(0,1),(1,0),(1,1), ovf=0, one done pulse.
- 4x4, tap4=1 and others 0, pixel value = address -> results 5,6,9,10.
- All taps=255, all pixels=255 -> res_data=60937 (585225 mod 65536), res_ovf=1.
- res_ready low for 5 cycles on the first result -> outputs stable and no mem_rd during the stall; pass then completes with correct values.
- coef_we tap0=7 and a second start issued mid-pass -> both ignored, and results match the original filter.
- rst asserted in FETCH of pixel 2 -> all outputs 0 next cycle and filter cleared. A fresh load and start then gives correct results.
